// File: rtl/audio_pkg.sv
// Shared definitions for the audio PWM player: player state encoding,
// default parameter values and the sample-to-duty conversion helper.
package audio_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPriming,
    StPlaying
  } player_state_t;

  localparam int unsigned SampleDivDef = 1134;  // 25 MHz / 1134 ~= 22.05 kHz
  localparam int unsigned FifoDepthDef = 16;
  localparam int unsigned PwmBitsDef   = 8;
  localparam int unsigned MidscaleDef  = 1 << (PwmBitsDef - 1);

  // Signed two's complement to offset binary: -32768 -> 0, 0 -> 0x8000.
  // The PWM duty is the top bits of this value.
  function automatic logic [15:0] offset_binary(input logic [15:0] s);
    return {~s[15], s[14:0]};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO holding audio samples.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         empties the FIFO at the next edge (wins over read/write)
//   wr_en_i/wr_data_i  push; accepted when not full or when a read happens too
//   rd_en_i         pop; rd_data_o always shows the head entry
//   full_o, empty_o, level_o  occupancy status
module sample_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [Width-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   level_q, level_d;
  logic             do_wr, do_rd;

  assign full_o    = (level_q == (AddrW + 1)'(Depth));
  assign empty_o   = (level_q == '0);
  assign do_wr     = wr_en_i && (!full_o || rd_en_i);
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; occupancy tracking makes stale entries invisible.
  always_ff @(posedge clk_i) begin
    if (do_wr && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/audio_pwm_player.sv
// Buffered audio player: samples are queued in a FIFO, released at the
// sample rate, converted to an unsigned duty and played as PWM.
// Ports:
//   clk_25mhz, reset_n  system clock, asynchronous active-low reset
//   sample_in/sample_valid  signed 16-bit sample and its one-cycle strobe
//   enable              playback enable; low flushes and parks at midscale
//   clear_flags         one-cycle strobe clearing overflow/underrun
//   pwm_out             registered PWM output
//   fifo_level          buffer occupancy
//   overflow, underrun  sticky error flags
module audio_pwm_player
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = SampleDivDef,
  parameter int unsigned FIFO_DEPTH = FifoDepthDef,
  parameter int unsigned PWM_BITS   = PwmBitsDef
) (
  input  logic                          clk_25mhz,
  input  logic                          reset_n,
  input  logic [15:0]                   sample_in,
  input  logic                          sample_valid,
  input  logic                          enable,
  input  logic                          clear_flags,
  output logic                          pwm_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CntW-1:0]     CntLast  = CntW'(SAMPLE_DIV - 1);
  localparam logic [PWM_BITS-1:0] Midscale = PWM_BITS'(1 << (PWM_BITS - 1));

  player_state_t       state_q, state_d;
  logic [CntW-1:0]     div_cnt_q, div_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] duty_next_q, duty_next_d;
  logic [PWM_BITS-1:0] duty_cur;
  logic                pwm_out_q, pwm_out_d;
  logic                overflow_q, overflow_d;
  logic                underrun_q, underrun_d;

  logic                tick, flush, fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [15:0]         fifo_rdata, rdata_ob;
  logic [LvlW-1:0]     level;
  logic                unused_rdata;

  // Disabling empties the buffer at the same edge that parks the FSM in idle.
  assign flush   = !enable;
  assign tick    = (state_q == StPlaying) && (div_cnt_q == CntLast);
  assign fifo_rd = tick && enable && !fifo_empty;
  // A write into a full FIFO still succeeds when a pop frees a slot that cycle.
  assign fifo_wr = sample_valid && enable && (!fifo_full || fifo_rd);

  assign rdata_ob     = offset_binary(fifo_rdata);
  assign unused_rdata = ^rdata_ob;

  sample_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (16)
  ) u_sample_fifo (
    .clk_i     (clk_25mhz),
    .rst_ni    (reset_n),
    .flush_i   (flush),
    .wr_en_i   (fifo_wr),
    .wr_data_i (sample_in),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  always_comb begin
    state_d   = state_q;
    div_cnt_d = '0;
    case (state_q)
      StIdle:    state_d = StPriming;
      StPriming: if (level >= LvlW'(FIFO_DEPTH / 2)) state_d = StPlaying;
      StPlaying: begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        if (tick && fifo_empty) state_d = StPriming;
      end
      default:   state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;

    duty_next_d = duty_next_q;
    if (fifo_rd) duty_next_d = rdata_ob[15 -: PWM_BITS];
    if ((state_q == StIdle) || !enable) duty_next_d = Midscale;

    // New duty takes effect only at a period boundary so no period is split.
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    duty_cur  = (pwm_cnt_q == '0) ? duty_next_q : duty_q;
    duty_d    = duty_cur;
    pwm_out_d = (pwm_cnt_q < duty_cur);

    // Set events take priority over a same-cycle clear.
    overflow_d = (sample_valid && enable && fifo_full && !fifo_rd) ||
                 (overflow_q && !clear_flags);
    underrun_d = (tick && enable && fifo_empty) || (underrun_q && !clear_flags);
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      div_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      duty_q      <= Midscale;
      duty_next_q <= Midscale;
      pwm_out_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_q      <= duty_d;
      duty_next_q <= duty_next_d;
      pwm_out_q   <= pwm_out_d;
      overflow_q  <= overflow_d;
      underrun_q  <= underrun_d;
    end
  end

  assign pwm_out    = pwm_out_q;
  assign fifo_level = level;
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_audio_pwm_player.sv
// Self-checking bench for audio_pwm_player. Duties are measured by counting
// high cycles over any 256-cycle window in which the duty is stable; tick
// times are predicted from the write that completes priming.
module tb_audio_pwm_player;

  localparam int unsigned Div   = 1134;
  localparam int unsigned Depth = 16;

  logic        clk_25mhz;
  logic        reset_n;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        enable;
  logic        clear_flags;
  logic        pwm_out;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        underrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  audio_pwm_player #(
    .SAMPLE_DIV (Div),
    .FIFO_DEPTH (Depth),
    .PWM_BITS   (8)
  ) dut (
    .clk_25mhz    (clk_25mhz),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .enable       (enable),
    .clear_flags  (clear_flags),
    .pwm_out      (pwm_out),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .underrun     (underrun)
  );

  initial clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  // Reference conversion: shift the signed sample to unsigned and scale to 8 bits.
  function automatic int exp_duty(input logic [15:0] s);
    return (int'($signed(s)) + 32768) / 256;
  endfunction

  // Random sample whose duty differs from midscale, so holds are observable.
  function automatic logic [15:0] rand_sample();
    logic [15:0] s;
    s = 16'($urandom);
    if (exp_duty(s) == 128) s = s ^ 16'h4000;
    return s;
  endfunction

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk_25mhz);
  endtask

  task automatic write_one(input logic [15:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    @(negedge clk_25mhz);
    sample_valid = 1'b0;
  endtask

  task automatic measure_duty(output int hi);
    hi = 0;
    repeat (256) begin
      @(negedge clk_25mhz);
      if (pwm_out === 1'b1) hi++;
    end
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(negedge clk_25mhz);
    clear_flags = 1'b0;
  endtask

  task automatic go_idle();
    enable       = 1'b0;
    sample_valid = 1'b0;
    repeat (300) @(negedge clk_25mhz);
    pulse_clear();
  endtask

  task automatic test_reset();
    int hi;
    enable = 1'b0; sample_valid = 1'b0; clear_flags = 1'b0; sample_in = '0;
    reset_n = 1'b1;
    #5 reset_n = 1'b0;
    repeat (3) @(negedge clk_25mhz);
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL rst_pwm: got %b want 0", pwm_out); end
    checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rst_udr: got %b want 0", underrun); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk_25mhz);
    measure_duty(hi);
    checks++; if (hi != 128) begin failures++; $display("FAIL rst_duty: got %0d want 128", hi); end
  endtask

  task automatic test_priming_latency();
    int e, hi;
    go_idle();
    enable = 1'b1;
    repeat (8) write_one(16'h7FFF);
    e = cyc;
    checks++; if (fifo_level !== 5'd8) begin failures++; $display("FAIL prime_level: got %0d want 8", fifo_level); end
    wait_cyc(e + 40);
    measure_duty(hi);
    checks++; if (hi != 128) begin failures++; $display("FAIL prime_mid_duty: got %0d want 128", hi); end
    wait_cyc(e + Div);
    checks++; if (fifo_level !== 5'd8) begin failures++; $display("FAIL pre_tick_level: got %0d want 8", fifo_level); end
    wait_cyc(e + Div + 1);
    checks++; if (fifo_level !== 5'd7) begin failures++; $display("FAIL first_pop_level: got %0d want 7", fifo_level); end
    wait_cyc(e + Div + 400);
    measure_duty(hi);
    checks++; if (hi != 255) begin failures++; $display("FAIL full_scale_duty: got %0d want 255", hi); end
    repeat (9) write_one(16'h7FFF);
    checks++; if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
      failures++; $display("FAIL fill_to_full: level %0d ovf %b want 16 0", fifo_level, overflow);
    end
    write_one(16'h7FFF);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL play_overflow: got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid_play();
    int n, hi;
    n = 0;
    while (pwm_out !== 1'b1 && n < 300) begin @(negedge clk_25mhz); n++; end
    checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL pre_reset_pwm: got %b want 1", pwm_out); end
    #5 reset_n = 1'b0;
    #1;
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL async_rst_pwm: got %b want 0", pwm_out); end
    checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL async_rst_level: got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0 || underrun !== 1'b0) begin
      failures++; $display("FAIL async_rst_flags: ovf %b udr %b want 0 0", overflow, underrun);
    end
    enable = 1'b0;
    @(negedge clk_25mhz);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_25mhz);
    measure_duty(hi);
    checks++; if (hi != 128) begin failures++; $display("FAIL post_rst_duty: got %0d want 128", hi); end
  endtask

  task automatic test_conversion();
    logic [15:0] seq [8];
    int want [3];
    int e, hi;
    seq  = '{16'h8000, 16'h0000, 16'h4000, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
    want = '{0, 128, 192};
    go_idle();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) write_one(seq[i]);
    e = cyc;
    for (int k = 1; k <= 3; k++) begin
      wait_cyc(e + k * Div + 400);
      measure_duty(hi);
      checks++; if (hi != want[k-1]) begin failures++; $display("FAIL convert_%0d: got %0d want %0d", k, hi, want[k-1]); end
    end
  endtask

  task automatic test_random_underrun();
    logic [15:0] model_q [$];
    logic [15:0] s;
    int e, e2, hi, last;
    go_idle();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s = rand_sample();
      model_q.push_back(s);
      write_one(s);
    end
    e = cyc;
    last = 0;
    for (int k = 1; k <= 8; k++) begin
      wait_cyc(e + k * Div + 1);
      checks++; if (fifo_level !== 5'(8 - k)) begin
        failures++; $display("FAIL rand_level_%0d: got %0d want %0d", k, fifo_level, 8 - k);
      end
      wait_cyc(e + k * Div + 400);
      measure_duty(hi);
      last = exp_duty(model_q.pop_front());
      checks++; if (hi != last) begin failures++; $display("FAIL rand_duty_%0d: got %0d want %0d", k, hi, last); end
    end
    wait_cyc(e + 9 * Div);
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL early_underrun: got %b want 0", underrun); end
    wait_cyc(e + 9 * Div + 1);
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_set: got %b want 1", underrun); end
    wait_cyc(e + 9 * Div + 400);
    measure_duty(hi);
    checks++; if (hi != last) begin failures++; $display("FAIL underrun_hold: got %0d want %0d", hi, last); end
    pulse_clear();
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_clear: got %b want 0", underrun); end
    // Back in priming: refilling must restart the full sample-period latency.
    for (int i = 0; i < 8; i++) write_one(rand_sample());
    e2 = cyc;
    wait_cyc(e2 + Div);
    checks++; if (fifo_level !== 5'd8) begin failures++; $display("FAIL reprime_hold: got %0d want 8", fifo_level); end
    wait_cyc(e2 + Div + 1);
    checks++; if (fifo_level !== 5'd7) begin failures++; $display("FAIL reprime_pop: got %0d want 7", fifo_level); end
  endtask

  task automatic test_overflow();
    int e8;
    go_idle();
    enable = 1'b1;
    e8 = 0;
    for (int i = 0; i < 16; i++) begin
      write_one(16'h0100);
      if (i == 7) e8 = cyc;
    end
    checks++; if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
      failures++; $display("FAIL full_no_ovf: level %0d ovf %b want 16 0", fifo_level, overflow);
    end
    write_one(16'h0100);
    checks++; if (fifo_level !== 5'd16 || overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_17th: level %0d ovf %b want 16 1", fifo_level, overflow);
    end
    pulse_clear();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    sample_valid = 1'b1; clear_flags = 1'b1;
    @(negedge clk_25mhz);
    sample_valid = 1'b0; clear_flags = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL set_beats_clear: got %b want 1", overflow); end
    pulse_clear();
    wait_cyc(e8 + Div);
    checks++; if (fifo_level !== 5'd16) begin failures++; $display("FAIL full_before_tick: got %0d want 16", fifo_level); end
    write_one(16'h0200);  // lands in the tick cycle
    checks++; if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
      failures++; $display("FAIL full_rw: level %0d ovf %b want 16 0", fifo_level, overflow);
    end
    enable = 1'b0;
    write_one(16'h0300);
    checks++; if (fifo_level !== 5'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL disabled_write: level %0d ovf %b want 0 0", fifo_level, overflow);
    end
    write_one(16'h0300);
    checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL disabled_ignored: got %0d want 0", fifo_level); end
  endtask

  task automatic test_disable();
    logic [15:0] s [8];
    int e, hi;
    go_idle();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s[i] = rand_sample();
      write_one(s[i]);
    end
    e = cyc;
    wait_cyc(e + 3 * Div + 400);
    measure_duty(hi);
    checks++; if (hi != exp_duty(s[2])) begin failures++; $display("FAIL pre_disable_duty: got %0d want %0d", hi, exp_duty(s[2])); end
    wait_cyc(e + 4 * Div);
    checks++; if (fifo_level !== 5'd5) begin failures++; $display("FAIL pre_disable_level: got %0d want 5", fifo_level); end
    enable = 1'b0;  // falls in the fourth tick cycle
    @(negedge clk_25mhz);
    checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL disable_flush: got %0d want 0", fifo_level); end
    repeat (258) @(negedge clk_25mhz);
    measure_duty(hi);
    checks++; if (hi != 128) begin failures++; $display("FAIL disable_midscale: got %0d want 128", hi); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL disable_udr: got %b want 0", underrun); end
  endtask

  initial begin
    test_reset();
    test_priming_latency();
    test_reset_mid_play();
    test_conversion();
    test_random_underrun();
    test_overflow();
    test_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
